// File: rtl/status_branch_unit.sv
// Status register, conditional-branch resolver and program counter.
// A branch moves IDLE -> EVAL -> UPD -> IDLE. br_done and taken pulse in the cycle after the UPD edge.
module status_branch_unit #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loads,
  input  logic             Z_in,
  input  logic             N_in,
  input  logic             V_in,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic             pc_inc,
  input  logic             pc_load,
  input  logic [PC_W-1:0]  pc_load_val,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       status,
  output logic             taken,
  output logic             br_done,
  output logic             illegal
);

  typedef enum logic [1:0] {StIdle, StEval, StUpd} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        status_q;
  logic [2:0]        cond_q;
  logic [IMM_W-1:0]  imm_q;
  logic              dec_q;
  logic              br_ill_q;
  logic              discard_q;
  logic              taken_q;
  logic              done_q;
  logic              illegal_q;

  logic              accept;
  logic              cond_taken;
  logic              cond_ill;
  logic [PC_W-1:0]   imm_ext;

  assign br_ready = reset && (state_q == StIdle);
  assign accept   = br_valid && br_ready;
  assign imm_ext  = {{(PC_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  // Status bits are {Z, N, V}.
  always_comb begin
    cond_taken = 1'b0;
    cond_ill   = 1'b0;
    case (cond_q)
      3'b000:  cond_taken = 1'b1;
      3'b001:  cond_taken = status_q[2];
      3'b010:  cond_taken = !status_q[2];
      3'b011:  cond_taken = status_q[1] ^ status_q[0];
      3'b100:  cond_taken = status_q[2] | (status_q[1] ^ status_q[0]);
      default: cond_ill   = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StEval;
      StEval:  state_d = StUpd;
      StUpd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // pc_load wins over the branch write, which wins over pc_inc.
  always_comb begin
    pc_d = pc_q;
    if (pc_load) begin
      pc_d = pc_load_val;
    end else if (state_q == StUpd) begin
      if (!discard_q && !br_ill_q) begin
        pc_d = dec_q ? (pc_q + PC_W'(1) + imm_ext) : (pc_q + PC_W'(1));
      end
    end else if (state_q == StIdle && !accept && pc_inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      status_q  <= '0;
      cond_q    <= '0;
      imm_q     <= '0;
      dec_q     <= 1'b0;
      br_ill_q  <= 1'b0;
      discard_q <= 1'b0;
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (loads) status_q <= {Z_in, N_in, V_in};
      if (accept) begin
        cond_q <= cond;
        imm_q  <= imm;
      end
      // A pc_load while a branch is in flight cancels that branch's pc write.
      if (accept) begin
        discard_q <= 1'b0;
      end else if (pc_load && state_q != StIdle) begin
        discard_q <= 1'b1;
      end
      if (state_q == StEval) begin
        dec_q    <= cond_taken;
        br_ill_q <= cond_ill;
        if (cond_ill) illegal_q <= 1'b1;
      end
      done_q  <= (state_q == StUpd);
      taken_q <= (state_q == StUpd) && dec_q;
    end
  end

  assign pc      = pc_q;
  assign status  = status_q;
  assign taken   = taken_q;
  assign br_done = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_status_branch_unit.sv
// Bench for status_branch_unit: cycle-level reference model compared every cycle,
// plus directed branches with hand-computed PC and taken expectations.
module tb_status_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       loads;
  logic       Z_in, N_in, V_in;
  logic       br_valid;
  logic       br_ready;
  logic [2:0] cond;
  logic [7:0] imm;
  logic       pc_inc;
  logic       pc_load;
  logic [8:0] pc_load_val;
  logic [8:0] pc;
  logic [2:0] status;
  logic       taken;
  logic       br_done;
  logic       illegal;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  status_branch_unit #(.PC_W(9), .IMM_W(8)) dut (
    .clk(clk), .reset(reset), .loads(loads), .Z_in(Z_in), .N_in(N_in), .V_in(V_in),
    .br_valid(br_valid), .br_ready(br_ready), .cond(cond), .imm(imm),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val), .pc(pc),
    .status(status), .taken(taken), .br_done(br_done), .illegal(illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {illegal, taken} straight from the branch rules.
  function automatic logic [1:0] resolve(input logic [2:0] c, input logic [2:0] st);
    logic z, n, v;
    z = st[2]; n = st[1]; v = st[0];
    case (c)
      3'd0:    return 2'b01;
      3'd1:    return {1'b0, z};
      3'd2:    return {1'b0, !z};
      3'd3:    return {1'b0, n != v};
      3'd4:    return {1'b0, z || (n != v)};
      default: return 2'b10;
    endcase
  endfunction

  // Reference model: a branch is remembered with its age in edges since acceptance.
  logic [8:0] m_pc;
  logic [2:0] m_status;
  logic       m_busy, m_dec, m_bill, m_discard, m_taken, m_done, m_illegal;
  int         m_age;
  logic [2:0] m_cond;
  logic [7:0] m_imm;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc <= '0; m_status <= '0; m_busy <= 1'b0; m_age <= 0; m_dec <= 1'b0;
      m_bill <= 1'b0; m_discard <= 1'b0; m_taken <= 1'b0; m_done <= 1'b0;
      m_illegal <= 1'b0; m_cond <= '0; m_imm <= '0;
    end else begin
      m_done  <= 1'b0;
      m_taken <= 1'b0;
      if (loads) m_status <= {Z_in, N_in, V_in};
      if (!m_busy && br_valid) begin
        m_busy <= 1'b1; m_age <= 1; m_cond <= cond; m_imm <= imm; m_discard <= 1'b0;
      end else if (m_busy && pc_load) begin
        m_discard <= 1'b1;
      end
      if (m_busy && m_age == 1) begin
        m_dec  <= resolve(m_cond, m_status) == 2'b01;
        m_bill <= resolve(m_cond, m_status) == 2'b10;
        if (resolve(m_cond, m_status) == 2'b10) m_illegal <= 1'b1;
        m_age  <= 2;
      end
      if (m_busy && m_age == 2) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_taken <= m_dec; m_age <= 0;
      end
      if (pc_load) begin
        m_pc <= pc_load_val;
      end else if (m_busy && m_age == 2) begin
        if (!m_discard && !m_bill)
          m_pc <= 9'(int'(m_pc) + 1 + (m_dec ? int'($signed(m_imm)) : 0));
      end else if (!m_busy && !br_valid && pc_inc) begin
        m_pc <= m_pc + 9'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model pc", pc, m_pc);
      check("model status", status, m_status);
      check("model br_ready", br_ready, reset && !m_busy);
      check("model br_done", br_done, m_done);
      check("model taken", taken, m_taken);
      check("model illegal", illegal, m_illegal);
    end
  end

  task automatic set_pc(input logic [8:0] v);
    @(negedge clk); pc_load = 1'b1; pc_load_val = v;
    @(negedge clk); pc_load = 1'b0;
  endtask

  task automatic set_flags(input logic [2:0] f);
    @(negedge clk); loads = 1'b1; {Z_in, N_in, V_in} = f;
    @(negedge clk); loads = 1'b0;
  endtask

  task automatic branch(input string name, input logic [2:0] c, input logic [7:0] im,
                        input bit ev_ld, input logic [2:0] ev_fl,
                        input bit up_ld, input logic [8:0] up_val,
                        input logic exp_taken, input logic [8:0] exp_pc);
    int lat;
    lat = 0;
    @(negedge clk); br_valid = 1'b1; cond = c; imm = im;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        br_valid = 1'b0; loads = ev_ld; {Z_in, N_in, V_in} = ev_fl;
      end else if (k == 2) begin
        loads = 1'b0; pc_load = up_ld; pc_load_val = up_val;
      end else if (k == 3) begin
        pc_load = 1'b0;
      end
      if (br_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({name, " latency"}, lat, 3);
    check({name, " taken"}, taken, exp_taken);
    check({name, " pc"}, pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    reset = 1'b0; loads = 1'b0; Z_in = 1'b0; N_in = 1'b0; V_in = 1'b0;
    br_valid = 1'b0; cond = '0; imm = '0; pc_inc = 1'b0; pc_load = 1'b0; pc_load_val = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("br_ready in reset", br_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("reset pc", pc, 9'h000);
    check("reset status", status, 3'b000);
    check("reset br_ready", br_ready, 1'b1);
    check("reset flags", {taken, br_done, illegal}, 3'b000);

    pc_inc = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk); pc_inc = 1'b0;
    check("pc_inc x16", pc, 9'h010);

    set_flags(3'b100);
    check("status Z", status, 3'b100);
    branch("beq", 3'b001, 8'h05, 1'b0, 3'b000, 1'b0, 9'h0, 1'b1, 9'h016);
    branch("bne", 3'b010, 8'h05, 1'b0, 3'b000, 1'b0, 9'h0, 1'b0, 9'h017);

    set_pc(9'h010);
    set_flags(3'b010);
    branch("blt nv", 3'b011, 8'h80, 1'b0, 3'b000, 1'b0, 9'h0, 1'b1, 9'h191);
    set_flags(3'b011);
    branch("blt nn", 3'b011, 8'h80, 1'b0, 3'b000, 1'b0, 9'h0, 1'b0, 9'h192);
    set_flags(3'b100);
    branch("ble z", 3'b100, 8'h01, 1'b0, 3'b000, 1'b0, 9'h0, 1'b1, 9'h194);

    set_pc(9'h1FF);
    branch("wrap up", 3'b000, 8'h00, 1'b0, 3'b000, 1'b0, 9'h0, 1'b1, 9'h000);
    set_pc(9'h000);
    branch("wrap down", 3'b000, 8'hFF, 1'b0, 3'b000, 1'b0, 9'h0, 1'b1, 9'h000);

    set_flags(3'b000);
    branch("late load", 3'b001, 8'h05, 1'b1, 3'b100, 1'b0, 9'h0, 1'b0, 9'h001);
    check("status after late load", status, 3'b100);
    branch("pc_load in upd", 3'b000, 8'h05, 1'b0, 3'b000, 1'b1, 9'h0AA, 1'b1, 9'h0AA);

    branch("illegal", 3'b110, 8'h05, 1'b0, 3'b000, 1'b0, 9'h0, 1'b0, 9'h0AA);
    check("illegal set", illegal, 1'b1);
    branch("after illegal", 3'b000, 8'h00, 1'b0, 3'b000, 1'b0, 9'h0, 1'b1, 9'h0AB);
    check("illegal sticky", illegal, 1'b1);

    set_pc(9'h050);
    @(negedge clk); br_valid = 1'b1; cond = 3'b000; imm = 8'h03;
    @(posedge clk);
    @(negedge clk); br_valid = 1'b0; reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (br_done === 1'b1) dones++;
    end
    check("abort no br_done", dones, 0);
    check("abort pc", pc, 9'h000);
    check("abort illegal cleared", illegal, 1'b0);
    check("abort br_ready", br_ready, 1'b1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
